fpu_minmax_reduce16: RTL and testbench



---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fp16_compare.sv | 27 ++
 rtl/fpu_minmax_reduce16.sv | 115 +++++++++++
 tb/tb_fpu_minmax_reduce16.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared fp16 types, constants and helpers for the FPU datapath
package fpu_pkg;

   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [9:0] frac;
   } fp16_t;

   // Raw sign-magnitude ordering of a against b
   typedef enum logic [1:0] {
      CMP_LT,
      CMP_EQ,
      CMP_GT
   } fp16_cmp_t;

   localparam fp16_t FP16_QNAN = 16'h7E00;

   function automatic logic fp16IsNaN(input fp16_t v);
      return (v.exp == 5'h1F) && (v.frac != 10'd0);
   endfunction

endpackage

// File: rtl/fp16_compare.sv
// rtl/fp16_compare.sv - combinational fp16 comparator using raw sign-magnitude ordering
module fp16_compare
   import fpu_pkg::*;
(
   input  fp16_t     a,
   input  fp16_t     b,
   output fp16_cmp_t order
);

   logic [15:0] keyA;
   logic [15:0] keyB;

   // Fold sign-magnitude into an unsigned key: negatives invert so larger magnitude
   // sorts lower, and -0 lands just below +0.
   assign keyA = a.sign ? {1'b0, ~{a.exp, a.frac}} : {1'b1, a.exp, a.frac};
   assign keyB = b.sign ? {1'b0, ~{b.exp, b.frac}} : {1'b1, b.exp, b.frac};

   always_comb begin
      order = CMP_EQ;
      if (keyA < keyB) begin
         order = CMP_LT;
      end else if (keyA > keyB) begin
         order = CMP_GT;
      end
   end

endmodule

// File: rtl/fpu_minmax_reduce16.sv
// rtl/fpu_minmax_reduce16.sv - streaming fp16 min/max/argmin/argmax reduction per vector
module fpu_minmax_reduce16
   import fpu_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inValid,
   output logic             inReady,
   input  fp16_t            inData,
   input  logic             inLast,
   output logic             outValid,
   input  logic             outReady,
   output fp16_t            outMin,
   output fp16_t            outMax,
   output logic [IDX_W-1:0] outMinIdx,
   output logic [IDX_W-1:0] outMaxIdx,
   output logic [IDX_W:0]   outCount,
   output logic             outNanSeen,
   output logic             outOverflow
);

   typedef enum logic {
      ACCUM,
      DONE
   } stateT;

   stateT     state;
   stateT     nextState;
   logic      haveVal;
   logic      accept;
   logic      clear;
   logic      full;
   logic      inNaN;
   fp16_cmp_t minOrder;
   fp16_cmp_t maxOrder;

   fp16_compare uMinCmp (.a(inData), .b(outMin), .order(minOrder));
   fp16_compare uMaxCmp (.a(inData), .b(outMax), .order(maxOrder));

   assign accept = inValid & inReady;
   assign clear  = reset | ((state == DONE) & outReady);
   // Count has reached 2**IDX_W once its top bit is set.
   assign full   = outCount[IDX_W];
   assign inNaN  = fp16IsNaN(inData);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ACCUM;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      inReady   = 1'b0;
      outValid  = 1'b0;
      case (state)
         ACCUM: begin
            inReady = 1'b1;
            if (inValid && inLast) begin
               nextState = DONE;
            end
         end
         DONE: begin
            outValid = 1'b1;
            if (outReady) begin
               nextState = ACCUM;
            end
         end
         default: nextState = ACCUM;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         outMin      <= FP16_QNAN;
         outMax      <= FP16_QNAN;
         outMinIdx   <= '0;
         outMaxIdx   <= '0;
         outCount    <= '0;
         outNanSeen  <= 1'b0;
         outOverflow <= 1'b0;
         haveVal     <= 1'b0;
      end else if (accept) begin
         if (full) begin
            outOverflow <= 1'b1;
         end else begin
            outCount <= outCount + {{IDX_W{1'b0}}, 1'b1};
            if (inNaN) begin
               outNanSeen <= 1'b1;
            end else if (!haveVal) begin
               outMin    <= inData;
               outMax    <= inData;
               outMinIdx <= outCount[IDX_W-1:0];
               outMaxIdx <= outCount[IDX_W-1:0];
               haveVal   <= 1'b1;
            end else begin
               // Strict compares only: a tie keeps the earlier index.
               if (minOrder == CMP_LT) begin
                  outMin    <= inData;
                  outMinIdx <= outCount[IDX_W-1:0];
               end
               if (maxOrder == CMP_GT) begin
                  outMax    <= inData;
                  outMaxIdx <= outCount[IDX_W-1:0];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fpu_minmax_reduce16.sv
// tb/tb_fpu_minmax_reduce16.sv - self-checking bench for fpu_minmax_reduce16 with a real-valued reference model
module tb_fpu_minmax_reduce16;

   localparam int W   = 2;
   localparam int CAP = 1 << W;

   logic          clock = 1'b0;
   logic          reset;
   logic          inValid;
   logic          inLast;
   logic          outReady;
   logic [15:0]   inData;
   logic          inReady;
   logic          outValid;
   logic [15:0]   outMin;
   logic [15:0]   outMax;
   logic [W-1:0]  outMinIdx;
   logic [W-1:0]  outMaxIdx;
   logic [W:0]    outCount;
   logic          outNanSeen;
   logic          outOverflow;

   int nChecks = 0;
   int nFails  = 0;

   logic [15:0] vecQ[$];
   logic [15:0] stim[$];
   bit          pending   = 1'b0;
   bit          modelInit = 1'b0;

   always #5 clock = ~clock;

   fpu_minmax_reduce16 #(.IDX_W(W)) dut (
      .clock(clock), .reset(reset),
      .inValid(inValid), .inReady(inReady), .inData(inData), .inLast(inLast),
      .outValid(outValid), .outReady(outReady),
      .outMin(outMin), .outMax(outMax), .outMinIdx(outMinIdx), .outMaxIdx(outMaxIdx),
      .outCount(outCount), .outNanSeen(outNanSeen), .outOverflow(outOverflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      nChecks++;
      nFails++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   function automatic bit isNan(input logic [15:0] d);
      return (d[14:10] == 5'h1F) && (d[9:0] != 10'd0);
   endfunction

   function automatic real toReal(input logic [15:0] d);
      real mag;
      int  e = int'(d[14:10]);
      int  f = int'(d[9:0]);
      if (e == 31)     mag = 1.0e9;
      else if (e == 0) mag = f * $pow(2.0, -24.0);
      else             mag = (1024 + f) * $pow(2.0, real'(e - 25));
      return d[15] ? -mag : mag;
   endfunction

   // Numeric order, with -0 placed below +0
   function automatic bit less(input logic [15:0] a, input logic [15:0] b);
      real ra = toReal(a);
      real rb = toReal(b);
      return (ra < rb) || ((ra == rb) && a[15] && !b[15]);
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         vecQ.delete();
         pending   = 1'b0;
         modelInit = 1'b1;
      end else if (modelInit) begin
         if (pending) begin
            if (outReady) begin
               pending = 1'b0;
               vecQ.delete();
            end
         end else if (inValid) begin
            vecQ.push_back(inData);
            if (inLast) pending = 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      logic [15:0] eMin, eMax, d;
      int          eMinIdx, eMaxIdx, eCount;
      bit          eNan, eOvf, have;
      if (modelInit) begin
         check("inReady", inReady, !pending);
         check("outValid", outValid, pending);
         if (pending || vecQ.size() == 0) begin
            eCount  = (vecQ.size() > CAP) ? CAP : vecQ.size();
            eOvf    = vecQ.size() > CAP;
            eMin    = 16'h7E00;
            eMax    = 16'h7E00;
            eMinIdx = 0;
            eMaxIdx = 0;
            eNan    = 1'b0;
            have    = 1'b0;
            for (int i = 0; i < eCount; i++) begin
               d = vecQ[i];
               if (isNan(d)) begin
                  eNan = 1'b1;
               end else if (!have) begin
                  eMin = d; eMax = d; eMinIdx = i; eMaxIdx = i; have = 1'b1;
               end else begin
                  if (less(d, eMin)) begin eMin = d; eMinIdx = i; end
                  if (less(eMax, d)) begin eMax = d; eMaxIdx = i; end
               end
            end
            check("modelMin", outMin, eMin);
            check("modelMax", outMax, eMax);
            check("modelMinIdx", outMinIdx, eMinIdx);
            check("modelMaxIdx", outMaxIdx, eMaxIdx);
            check("modelCount", outCount, eCount);
            check("modelNan", outNanSeen, eNan);
            check("modelOvf", outOverflow, eOvf);
         end
      end
   end

   task automatic sendElem(input logic [15:0] d, input bit last);
      int budget = 50;
      inValid = 1'b1;
      inData  = d;
      inLast  = last;
      while (!inReady && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      if (budget == 0) timeoutFail("sendElem");
      @(negedge clock);
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   task automatic sendStim(input bit gaps);
      foreach (stim[i]) begin
         if (gaps) repeat ($urandom_range(0, 1)) @(negedge clock);
         sendElem(stim[i], i == stim.size() - 1);
      end
   endtask

   task automatic waitValid();
      int budget = 20;
      while (!outValid && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      if (budget == 0) timeoutFail("waitValid");
   endtask

   task automatic releaseResult(input int hold);
      repeat (hold) @(negedge clock);
      outReady = 1'b1;
      @(negedge clock);
      outReady = 1'b0;
   endtask

   task automatic expectLit(input string tag, input logic [15:0] mn, input int mnIdx,
                            input logic [15:0] mx, input int mxIdx, input int cnt,
                            input bit nan, input bit ovf);
      waitValid();
      check({tag, ".min"}, outMin, mn);
      check({tag, ".minIdx"}, outMinIdx, mnIdx);
      check({tag, ".max"}, outMax, mx);
      check({tag, ".maxIdx"}, outMaxIdx, mxIdx);
      check({tag, ".count"}, outCount, cnt);
      check({tag, ".nan"}, outNanSeen, nan);
      check({tag, ".ovf"}, outOverflow, ovf);
      releaseResult(0);
   endtask

   task automatic checkResetVals(input string tag);
      check({tag, ".inReady"}, inReady, 1);
      check({tag, ".outValid"}, outValid, 0);
      check({tag, ".min"}, outMin, 16'h7E00);
      check({tag, ".max"}, outMax, 16'h7E00);
      check({tag, ".idx"}, {outMinIdx, outMaxIdx}, 0);
      check({tag, ".count"}, outCount, 0);
      check({tag, ".flags"}, {outNanSeen, outOverflow}, 0);
   endtask

   function automatic logic [15:0] randElem(input int idx, input logic [15:0] prev);
      logic [15:0] d;
      case ($urandom_range(0, 3))
         0: d = 16'($urandom);
         1: case ($urandom_range(0, 8))
               0: d = 16'h0000;  1: d = 16'h8000;  2: d = 16'h7C00;
               3: d = 16'hFC00;  4: d = 16'h7E00;  5: d = 16'h0001;
               6: d = 16'h8001;  7: d = 16'h3C00;  default: d = 16'hBC00;
            endcase
         2: d = prev;
         default: d = {1'($urandom_range(0, 1)), 5'($urandom_range(13, 17)), 10'($urandom_range(0, 3))};
      endcase
      if (idx >= CAP && isNan(d)) d = 16'h3C00;
      return d;
   endfunction

   initial begin
      int          len;
      logic [15:0] prev;
      reset    = 1'b1;
      inValid  = 1'b0;
      inLast   = 1'b0;
      inData   = 16'h0000;
      outReady = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      checkResetVals("reset");

      stim = {16'h4200, 16'hBC00, 16'h4500, 16'hBC00};
      sendStim(1'b0);
      expectLit("mixed", 16'hBC00, 1, 16'h4500, 2, 4, 1'b0, 1'b0);

      stim = {16'h7E00, 16'h3C00, 16'h7C01};
      sendStim(1'b0);
      expectLit("nanMix", 16'h3C00, 1, 16'h3C00, 1, 3, 1'b1, 1'b0);

      stim = {16'h7E00};
      sendStim(1'b0);
      expectLit("allNan", 16'h7E00, 0, 16'h7E00, 0, 1, 1'b1, 1'b0);

      stim = {16'h0000, 16'h8000};
      sendStim(1'b0);
      expectLit("zeros", 16'h8000, 1, 16'h0000, 0, 2, 1'b0, 1'b0);

      stim = {16'hFC00, 16'h7C00};
      sendStim(1'b0);
      expectLit("infs", 16'hFC00, 0, 16'h7C00, 1, 2, 1'b0, 1'b0);

      stim = {16'h4000};
      sendStim(1'b0);
      waitValid();
      for (int k = 0; k < 5; k++) begin
         inValid = 1'b1;
         inData  = 16'h0000;
         inLast  = 1'b1;
         check("bpValid", outValid, 1);
         check("bpReady", inReady, 0);
         check("bpMin", outMin, 16'h4000);
         @(negedge clock);
      end
      inValid  = 1'b0;
      inLast   = 1'b0;
      outReady = 1'b1;
      @(negedge clock);
      outReady = 1'b0;
      check("bpResume", inReady, 1);
      stim = {16'h3C00, 16'h4000};
      sendStim(1'b0);
      expectLit("afterBp", 16'h3C00, 0, 16'h4000, 1, 2, 1'b0, 1'b0);

      stim = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4000};
      sendStim(1'b0);
      expectLit("overflow", 16'h3C00, 0, 16'h3C00, 0, 4, 1'b0, 1'b1);

      sendElem(16'h4000, 1'b0);
      sendElem(16'h3C00, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkResetVals("midReset");
      stim = {16'h4000};
      sendStim(1'b0);
      expectLit("single", 16'h4000, 0, 16'h4000, 0, 1, 1'b0, 1'b0);

      stim = {16'hC000};
      sendStim(1'b0);
      waitValid();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkResetVals("doneReset");

      for (int v = 0; v < 60; v++) begin
         len  = $urandom_range(1, 7);
         prev = 16'h0000;
         stim = {};
         for (int i = 0; i < len; i++) begin
            prev = randElem(i, prev);
            stim.push_back(prev);
         end
         sendStim(1'b1);
         waitValid();
         releaseResult($urandom_range(0, 3));
      end

      repeat (2) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
